pc_sequencer: RTL
=================

# pc_sequencer

Program-counter controller for the MIPS pipeline fetch stage. It owns the PC register and uses one instance of the word incrementer to choose the next fetch address each cycle. The next address is sequential (PC+1), held for a stall, redirected to a branch or jump target, or frozen for a halt. It drives the instruction-memory address and tells IF/ID when the fetched word is meaningful and when to flush.

## Interface
Parameters:
- WIDTH, 32, PC and target width (word address; instruction memory is word-indexed)
- RESET_PC, 0, PC value loaded on reset
- REDIRECT_BUBBLES, 1, number of non-valid fetch cycles after an accepted redirect (legal range 1..7)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: do not advance PC at this edge
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  WIDTH  branch destination
- jump  in  1  ID-stage jump
- jump_target  in  WIDTH  jump destination
- halt  in  1  request to freeze fetch
- resume  in  1  leave HALTED
- pc  out  WIDTH  current fetch address (registered)
- pc_plus1  out  WIDTH  pc+1 from incrementer (combinational from pc), forwarded as link value
- pc_valid  out  1  fetch address is live (state RUN or STALL)
- flush  out  1  one-cycle pulse: kill IF/ID contents
- state  out  2  RUN=0, STALL=1, BUBBLE=2, HALTED=3

## Operation
- All inputs are sampled at the rising edge of clk, and one event is accepted per edge.
- Priority: rst > branch_taken > jump > halt > stall > sequential. The branch wins over the jump because it belongs to the older instruction.
- rst: pc=RESET_PC, state=RUN, bubble counter=0, flush=0, pc_valid=1.
- In RUN or STALL:
  - Redirect (branch or jump): pc<=target, state<=BUBBLE, counter<=REDIRECT_BUBBLES-1, flush<=1.
  - Otherwise halt: pc holds, state<=HALTED.
  - Otherwise stall: pc holds, state<=STALL.
  - Otherwise: pc<=pc_plus1, state<=RUN.
- In BUBBLE:
  - Redirect: reload pc with the new target, restart the counter at REDIRECT_BUBBLES-1, and pulse flush again.
  - Halt: state<=HALTED, pc holds target.
  - Stall is ignored.
  - When counter==0, state<=RUN and pc holds; the first valid fetch is the target. Otherwise the counter decrements.
- In HALTED:
  - Redirects and stall are ignored and pc holds.
  - resume leads to RUN, pc unchanged.
  - halt && resume together: remain HALTED.
- flush is 1 only in the cycle immediately following an accepted redirect; otherwise it is 0.
- Arithmetic: pc_plus1 = pc + 1 modulo 2^WIDTH, so 0xFFFFFFFF wraps to 0x00000000 with no flag.

## Timing
- PC latency: a redirect accepted at edge E gives pc=target in cycle E+1. pc_valid=0 for REDIRECT_BUBBLES cycles, then pc_valid=1 with pc=target. pc advances to target+1 at the following edge unless stalled.
- Sequential fetch: one new address per cycle with zero bubbles.
- The stall decision applies to the same edge it is sampled at; PC is never advanced past a stalled instruction.
- Reset mid-operation (any state, mid-bubble or halted) takes effect at that edge. It overrides all other inputs and clears a pending flush.
- All outputs except pc_plus1 are registered or decoded from registered state. There is no input-to-output combinational path.

## Structure
- Shared package `mips_pkg`: the state encoding typedef (RUN/STALL/BUBBLE/HALTED), WIDTH default, RESET_PC default.
- One sub-module: the existing `adder` word incrementer, instantiated once (add_in=pc, add_out=pc_plus1).
- The rest is a single FSM plus a 3-bit bubble counter and the pc register.

## Test plan
- Reset: hold rst 2 cycles, then release with no events. Required: pc=0,1,2,3 on successive cycles, pc_valid=1, flush=0.
- Stall: at pc=5, hold stall for 3 cycles. Required: pc=5 for 3 extra cycles, state=STALL, then pc=6 with state=RUN.
- Branch vs jump: at pc=8, assert branch_taken (target 0x40) and jump (target 0x80) together. Required: next cycle pc=0x40, flush=1, pc_valid=0, state=BUBBLE. The cycle after: RUN with pc=0x40, then 0x41.
- Redirect in bubble with REDIRECT_BUBBLES=3: jump to 0x10, then branch to 0x20 during the 2nd bubble cycle. Required: flush pulses twice, and pc=0x20 becomes valid 3 cycles after the second redirect.
- Halt and resume: halt at pc=0x30 while also asserting jump. Required: the jump wins (BUBBLE). A halt on the next cycle goes to HALTED with pc=0x30's target held, and stall or branch are ignored. resume then gives RUN with pc unchanged.
- Wrap and reset: pc=0xFFFFFFFF then pc=0x00000000. Asserting rst during HALTED or BUBBLE gives pc=RESET_PC, state=RUN, flush=0 at the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch-sequencer state encoding and PC defaults.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    BUBBLE = 2'd2,
    HALTED = 2'd3
  } pc_state_e;

  localparam int          PC_WIDTH_DEF = 32;
  localparam int unsigned RESET_PC_DEF = 32'd0;

endpackage

// File: rtl/adder.sv
// Word incrementer: add_out = add_in + 1, wrapping silently at 2^WIDTH.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] add_in,
  output logic [WIDTH-1:0] add_out
);

  assign add_out = add_in + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: sequential/stall/redirect/halt selection with a
// fixed number of dead fetch cycles after every accepted redirect.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int               WIDTH            = PC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_PC         = WIDTH'(RESET_PC_DEF),
  parameter int               REDIRECT_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             halt,
  input  logic             resume,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus1,
  output logic             pc_valid,
  output logic             flush,
  output logic [1:0]       state
);

  localparam logic [2:0] CNT_INIT = 3'(REDIRECT_BUBBLES - 1);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             redirect;
  logic [WIDTH-1:0] redirect_tgt;

  adder #(.WIDTH(WIDTH)) u_inc (
    .add_in  (pc_q),
    .add_out (pc_plus1)
  );

  // Branch beats jump: it belongs to the older instruction.
  assign redirect     = branch_taken | jump;
  assign redirect_tgt = branch_taken ? branch_target : jump_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    unique case (state_q)
      RUN, STALL: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = BUBBLE;
          cnt_d   = CNT_INIT;
          flush_d = 1'b1;
        end else if (halt) begin
          state_d = HALTED;
        end else if (stall) begin
          state_d = STALL;
        end else begin
          pc_d    = pc_plus1;
          state_d = RUN;
        end
      end
      BUBBLE: begin
        // pc already holds the target; stall has nothing to hold back here.
        if (redirect) begin
          pc_d    = redirect_tgt;
          cnt_d   = CNT_INIT;
          flush_d = 1'b1;
        end else if (halt) begin
          state_d = HALTED;
        end else if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      HALTED: begin
        if (resume && !halt) state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign state    = state_q;
  assign pc_valid = (state_q == RUN) || (state_q == STALL);

endmodule
